adc_frame_scheduler: RTL and testbench
======================================

// Module: adc_frame_scheduler
// PURPOSE
//   Sequences the ADS8528 parallel-mode driver at a fixed sample rate. Issues a conversion request
//   every SAMPLE_DIV clocks, tags each of the NUM_CH words returned by the driver with channel and
//   frame number, and buffers them in a word FIFO with a valid/ready output, adding the backpressure
//   the driver lacks. Sits between the driver and the localisation datapath.
// PARAMETERS
//   NUM_CH      8     words per conversion frame (power of 2, 2..8)
//   DATA_W      16    sample width
//   SAMPLE_DIV  1000  clocks between conversion ticks (>= 2)
//   TIMEOUT     255   max clocks spent in any single ARM/WAIT_BUSY/COLLECT wait before abort
//   FIFO_DEPTH  16    output FIFO depth in words (power of 2, >= NUM_CH)
// PORTS
//   clk          in   1        clock
//   aresetn      in   1        reset, asynchronous assert, active-low
//   enable       in   1        1 = tick counter runs; 0 = counter held at 0, no new frames
//   conv_req     out  1        to driver conv_start; high in ARM only
//   adc_busy     in   1        ADS8528 BUSY
//   s_valid      in   1        driver data_valid (single-cycle, no backpressure)
//   s_data       in   DATA_W   driver data_out
//   m_valid      out  1        output word valid
//   m_ready      in   1        output word accepted when m_valid & m_ready
//   m_data       out  DATA_W   sample
//   m_chan       out  log2(NUM_CH)  channel index 0..NUM_CH-1
//   m_last       out  1        1 on channel NUM_CH-1
//   m_frame      out  8        frame number, wraps 255->0
//   drop_count   out  16       frames skipped; saturates at 16'hFFFF
//   err_timeout  out  1        sticky: a frame was aborted by timeout
//   err_spurious out  1        sticky: s_valid seen outside COLLECT
//   clear_err    in   1        sync pulse: clears drop_count, err_timeout, err_spurious
// BEHAVIOUR
//   Reset: state IDLE, tick counter 0, FIFO empty, frame 0, conv_req/m_valid 0, counters/flags 0.
//   Tick: counter 0..SAMPLE_DIV-1 while enable; tick=1 on cycle counter==SAMPLE_DIV-1, then wraps.
//   FSM (wait counter cleared on every state entry):
//     IDLE      on tick: if FIFO free >= NUM_CH -> ARM, else drop_count++ and stay IDLE.
//     ARM       conv_req=1; adc_busy=1 -> WAIT_BUSY.
//     WAIT_BUSY adc_busy=0 -> COLLECT, chan counter=0.
//     COLLECT   each s_valid: push {frame,chan==NUM_CH-1,chan,s_data}, chan++;
//               push of chan NUM_CH-1 -> IDLE, frame++.
//     Timeout: wait counter reaching TIMEOUT in ARM/WAIT_BUSY/COLLECT -> IDLE, err_timeout=1,
//       frame++ (words already pushed stay in FIFO; no m_last for that frame).
//   Tick while not IDLE: drop_count++ (saturating); no queuing of ticks.
//   Free-space check at IDLE guarantees COLLECT never pushes into a full FIFO.
//   Output: show-ahead FIFO; word pushed at cycle t visible on m_valid at t+1 when FIFO empty.
//     Pop on m_valid&m_ready; simultaneous push/pop keeps occupancy. m_data/m_chan/m_last/m_frame
//     stable while m_valid&!m_ready.
//   s_valid outside COLLECT: data discarded, err_spurious=1.
//   clear_err coincident with a new drop/error event: event wins (counter=1 / flag=1).
//   enable falling mid-frame: current frame completes normally; only future ticks stop.
//   Reset asserted mid-frame: all state, FIFO contents and outputs return to reset values at once.
// TESTING
//   SAMPLE_DIV=20, driver model busy 3 clks after conv_req, 8 words; m_ready=1 -> 8 words chan 0..7,
//     m_last only on chan 7, frame 0 then frame 1 on next tick, drop_count=0.
//   m_ready=0 for 3 ticks, FIFO_DEPTH=16 -> frames 0,1 buffered, third tick drop_count=1, m_data held.
//   adc_busy never rises -> conv_req high 255 clks, then IDLE, err_timeout=1, frame increments.
//   Only 5 words returned -> timeout in COLLECT, 5 words out (chan 0..4, no m_last), err_timeout=1.
//   s_valid pulse in IDLE -> err_spurious=1, nothing pushed; clear_err -> flags 0, drop_count 0.
//   aresetn low mid-COLLECT -> conv_req=0, m_valid=0, frame=0 immediately; clean frame 0 after.

Source files
------------

// File: rtl/adc_frame_scheduler.sv
// ADS8528 frame scheduler: periodic conversion requests, per-word channel/frame tagging,
// and a show-ahead output FIFO with valid/ready backpressure plus drop/error status.
`timescale 1ns/1ps
module adc_frame_scheduler #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 16,
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  output logic              conv_req,
  input  logic              adc_busy,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_chan,
  output logic              m_last,
  output logic [7:0]        m_frame,
  output logic [15:0]       drop_count,
  output logic              err_timeout,
  output logic              err_spurious,
  input  logic              clear_err
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WORD_W = 8 + 1 + CH_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BUSY,
    S_COLLECT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIV_W-1:0]    r_tick_cnt;
  logic [TO_W-1:0]     r_wait;
  logic [CH_W-1:0]     r_chan;
  logic [7:0]          r_frame;
  logic [15:0]         r_drop_count;
  logic                r_err_timeout;
  logic                r_err_spurious;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];

  logic                w_tick;
  logic                w_room;
  logic                w_timeout;
  logic                w_chan_last;
  logic                w_push;
  logic                w_pop;
  logic                w_frame_done;
  logic                w_abort;
  logic                w_drop;
  logic                w_spurious;
  logic [WORD_W-1:0]   w_push_word;

  // Sample-rate tick: counter parks at 0 while disabled.
  assign w_tick = enable && (r_tick_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tick_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_room      = r_count <= CNT_W'(FIFO_DEPTH - NUM_CH);
  assign w_timeout   = r_wait == TO_W'(TIMEOUT - 1);
  assign w_chan_last = r_chan == CH_W'(NUM_CH - 1);

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_frame_done = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && w_room) begin
          w_state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (adc_busy) begin
          w_state_next = S_WAIT_BUSY;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      S_WAIT_BUSY: begin
        if (!adc_busy) begin
          w_state_next = S_COLLECT;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      S_COLLECT: begin
        w_push = s_valid;
        if (s_valid && w_chan_last) begin
          w_frame_done = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_wait <= '0;
      end else if (r_state != S_IDLE) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_chan  <= '0;
      r_frame <= '0;
    end else begin
      if (r_state == S_WAIT_BUSY && w_state_next == S_COLLECT) begin
        r_chan <= '0;
      end else if (w_push) begin
        r_chan <= r_chan + 1'b1;
      end
      if (w_frame_done || w_abort) begin
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  // Ticks are never queued: one arriving mid-frame or without room for a whole frame is lost.
  assign w_drop     = w_tick && ((r_state != S_IDLE) || !w_room);
  assign w_spurious = s_valid && (r_state != S_COLLECT);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_count   <= '0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_drop) begin
        if (clear_err) begin
          r_drop_count <= 16'd1;
        end else if (r_drop_count != 16'hFFFF) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
      end else if (clear_err) begin
        r_drop_count <= '0;
      end
      if (w_abort) begin
        r_err_timeout <= 1'b1;
      end else if (clear_err) begin
        r_err_timeout <= 1'b0;
      end
      if (w_spurious) begin
        r_err_spurious <= 1'b1;
      end else if (clear_err) begin
        r_err_spurious <= 1'b0;
      end
    end
  end

  // Output FIFO: show-ahead, head word read straight from the array.
  assign w_push_word = {r_frame, w_chan_last, r_chan, s_data};
  assign w_pop       = (r_count != '0) && m_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign {m_frame, m_last, m_chan, m_data} = r_mem[r_rd_ptr];
  assign m_valid      = r_count != '0;
  assign conv_req     = r_state == S_ARM;
  assign drop_count   = r_drop_count;
  assign err_timeout  = r_err_timeout;
  assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Bench for adc_frame_scheduler: driver stub, handshake logger, per-frame vector table,
// hand-written corner sequences and a randomized run checked against a word scoreboard.
`timescale 1ns/1ps
module tb_adc_frame_scheduler;

  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 16;
  localparam int SAMPLE_DIV = 20;
  localparam int TIMEOUT    = 255;
  localparam int FIFO_DEPTH = 16;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              enable = 1'b0;
  logic              conv_req;
  logic              adc_busy = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_chan;
  logic              m_last;
  logic [7:0]        m_frame;
  logic [15:0]       drop_count;
  logic              err_timeout;
  logic              err_spurious;
  logic              clear_err = 1'b0;

  adc_frame_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV),
    .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .conv_req(conv_req),
    .adc_busy(adc_busy), .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .m_last(m_last), .m_frame(m_frame), .drop_count(drop_count),
    .err_timeout(err_timeout), .err_spurious(err_spurious), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  frame;
    logic        last;
    logic [2:0]  chan;
    logic [15:0] data;
  } word_t;

  word_t exp_q[$];
  word_t got_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Driver stub controls and frame bookkeeping.
  int        drv_nwords = 8;
  bit        drv_busy = 1'b1;
  int        drv_gap_max = 0;
  logic [7:0] drv_frame = '0;
  int        drv_starts = 0;
  int        rdy_mode = 1;
  int        req_cycles = 0;

  // Reference tick count: one tick per SAMPLE_DIV consecutive enabled cycles.
  int        tick_cnt = 0;
  int        ticks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame();
    logic [7:0] f;
    word_t      w;
    f = drv_frame;
    drv_frame++;
    drv_starts++;
    if (!drv_busy) begin
      for (int k = 0; k < TIMEOUT + 40 && conv_req; k++) @(negedge clk);
      return;
    end
    repeat (3) @(negedge clk);
    adc_busy = 1'b1;
    repeat (4) @(negedge clk);
    adc_busy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < drv_nwords; i++) begin
      repeat ($urandom_range(drv_gap_max, 0)) @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      w.frame = f;
      w.last  = (i == NUM_CH - 1);
      w.chan  = 3'(i);
      w.data  = s_data;
      exp_q.push_back(w);
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  initial begin : driver
    forever begin
      @(negedge clk);
      if (aresetn && conv_req) run_frame();
    end
  end

  initial begin : monitor
    word_t w;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(2, 0) == 0);
      endcase
      if (conv_req) req_cycles++;
      if (aresetn && m_valid && m_ready) begin
        w.frame = m_frame;
        w.last  = m_last;
        w.chan  = m_chan;
        w.data  = m_data;
        got_q.push_back(w);
      end
    end
  end

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tick_cnt <= 0;
      ticks    <= 0;
    end else if (!enable) begin
      tick_cnt <= 0;
    end else if (tick_cnt == SAMPLE_DIV - 1) begin
      tick_cnt <= 0;
      ticks    <= ticks + 1;
    end else begin
      tick_cnt <= tick_cnt + 1;
    end
  end

  task automatic do_reset();
    aresetn   = 1'b0;
    enable    = 1'b0;
    clear_err = 1'b0;
    s_valid   = 1'b0;
    adc_busy  = 1'b0;
    cycles(3);
    exp_q.delete();
    got_q.delete();
    drv_frame  = '0;
    drv_starts = 0;
    aresetn    = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    cycles(1);
    clear_err = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (conv_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_stream(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check(name, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int nwords;
    bit busy;
    int exp_words;
    int exp_lasts;
    bit exp_to;
    int exp_frame;
    int exp_req;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int lasts;
    vecs[0] = '{8, 1'b1, 8, 1, 1'b0, 0, 4};
    vecs[1] = '{5, 1'b1, 5, 0, 1'b1, 1, 4};
    vecs[2] = '{0, 1'b0, 0, 0, 1'b1, 2, TIMEOUT};
    vecs[3] = '{0, 1'b1, 0, 0, 1'b1, 3, 4};
    vecs[4] = '{8, 1'b1, 8, 1, 1'b0, 4, 4};

    do_reset();
    #1;
    check("rst_conv_req", conv_req, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_drop", drop_count, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_spurious", err_spurious, 0);

    // One frame per vector: normal, short (COLLECT timeout), no busy (ARM timeout), empty COLLECT.
    for (int v = 0; v < 5; v++) begin
      drv_nwords  = vecs[v].nwords;
      drv_busy    = vecs[v].busy;
      drv_gap_max = 0;
      rdy_mode    = 1;
      pulse_clear();
      req_cycles = 0;
      enable = 1'b1;
      wait_req(ok);
      check("vec_req_seen", ok, 1);
      enable = 1'b0;
      cycles(300);
      check("vec_req_cycles", req_cycles, vecs[v].exp_req);
      check("vec_words", got_q.size(), vecs[v].exp_words);
      lasts = 0;
      for (int i = 0; i < got_q.size(); i++) begin
        if (got_q[i].last) lasts++;
        check("vec_frame", got_q[i].frame, vecs[v].exp_frame);
        check("vec_chan", got_q[i].chan, i);
      end
      check("vec_lasts", lasts, vecs[v].exp_lasts);
      check("vec_err_timeout", err_timeout, vecs[v].exp_to);
      check("vec_drop", drop_count, 0);
      check("vec_conv_req_idle", conv_req, 0);
      $display("vector %0d: nwords=%0d busy=%0d words_out=%0d timeout=%0b",
               v, vecs[v].nwords, vecs[v].busy, got_q.size(), err_timeout);
      check_stream("vec_data");
    end

    // Backpressure: two frames fill the FIFO, the third tick is dropped, head word held.
    do_reset();
    drv_nwords = 8; drv_busy = 1'b1; drv_gap_max = 0; rdy_mode = 0;
    enable = 1'b1;
    cycles(62);
    enable = 1'b0;
    cycles(10);
    check("bp_drop", drop_count, 1);
    check("bp_valid", m_valid, 1);
    check("bp_buffered", exp_q.size(), 16);
    if (exp_q.size() > 0) begin
      check("bp_head", {m_frame, m_last, m_chan, m_data}, 32'(exp_q[0]));
      cycles(5);
      check("bp_hold", {m_frame, m_last, m_chan, m_data}, 32'(exp_q[0]));
    end
    rdy_mode = 1;
    cycles(30);
    $display("backpressure: drained %0d words, drop_count=%0d", got_q.size(), drop_count);
    check_stream("bp_stream");
    check("bp_empty", m_valid, 0);

    // Spurious s_valid in IDLE, clear coincident with the event, then a plain clear.
    s_valid = 1'b1; s_data = 16'hBEEF;
    cycles(1);
    s_valid = 1'b0;
    cycles(2);
    check("sp_flag", err_spurious, 1);
    check("sp_no_push", m_valid, 0);
    clear_err = 1'b1; s_valid = 1'b1;
    cycles(1);
    clear_err = 1'b0; s_valid = 1'b0;
    cycles(1);
    check("sp_event_wins", err_spurious, 1);
    check("sp_drop_cleared", drop_count, 0);
    pulse_clear();
    check("sp_cleared", err_spurious, 0);
    $display("spurious: flag cleared, drop_count=%0d", drop_count);

    // Reset in the middle of COLLECT, then a clean frame 0.
    do_reset();
    drv_gap_max = 0; rdy_mode = 0;
    enable = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (exp_q.size() >= 3) break;
    end
    check("mid_words_sent", exp_q.size() >= 3, 1);
    check("mid_pre_valid", m_valid, 1);
    aresetn = 1'b0;
    enable = 1'b0;
    #1;
    check("mid_conv_req", conv_req, 0);
    check("mid_m_valid", m_valid, 0);
    cycles(15);
    exp_q.delete(); got_q.delete();
    drv_frame = '0; drv_starts = 0;
    rdy_mode = 1;
    aresetn = 1'b1;
    enable = 1'b1;
    wait_req(ok);
    check("mid_req_again", ok, 1);
    enable = 1'b0;
    cycles(40);
    check("mid_clean_frame0", got_q.size() > 0 ? got_q[0].frame : 8'hFF, 0);
    $display("reset mid-frame: clean frame words=%0d", got_q.size());
    check_stream("mid_clean");
    check("mid_err_spurious", err_spurious, 0);

    // Randomized run: word gaps and m_ready random, scoreboard plus drop accounting.
    do_reset();
    drv_nwords = 8; drv_busy = 1'b1; drv_gap_max = 3; rdy_mode = 2;
    enable = 1'b1;
    cycles(2000);
    enable = 1'b0;
    cycles(60);
    rdy_mode = 1;
    cycles(40);
    $display("random: ticks=%0d frames=%0d drops=%0d words=%0d",
             ticks, drv_starts, drop_count, got_q.size());
    check_stream("rand_stream");
    check("rand_drop", drop_count, ticks - drv_starts);
    check("rand_err_timeout", err_timeout, 0);
    check("rand_err_spurious", err_spurious, 0);
    check("rand_empty", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
